// File: rtl/knn_topk_vote_if.sv
// Sample stream from the distance path into the k-NN top-K / vote block.
// The producer drives one distance and its class label per training row;
// the consumer raises dist_ready while it is collecting samples.
interface knn_topk_vote_if #(
   parameter int LABEL_W = 4
);
   logic               dist_valid;
   logic               dist_ready;
   logic [31:0]        dist_in;
   logic [LABEL_W-1:0] label_in;

   modport master (output dist_valid, output dist_in, output label_in, input dist_ready);
   modport slave  (input dist_valid, input dist_in, input label_in, output dist_ready);
endinterface

// File: rtl/knn_topk_vote.sv
// k-NN classifier back end: keeps the K nearest float32 distances in a
// sorted insertion table, then majority-votes their labels one slot per
// cycle and reports the winning class plus the nearest distance.
module knn_topk_vote #(
   parameter int K        = 3,
   parameter int NUM_ROWS = 8,
   parameter int LABEL_W  = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   knn_topk_vote_if.slave     dist_if,
   output logic               busy,
   output logic               done,
   output logic [LABEL_W-1:0] result_label,
   output logic [31:0]        min_dist
);
   localparam int CW   = $clog2(NUM_ROWS + 1);
   localparam int VW   = $clog2(K + 1);
   localparam int NCLS = 1 << LABEL_W;
   localparam logic [30:0] KEY_MAX = 31'h7FFF_FFFF;

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VOTE, S_DONE} state_t;

   state_t state_q, state_d;

   logic               tbl_vld [K];
   logic [30:0]        tbl_key [K];
   logic [31:0]        tbl_raw [K];
   logic [LABEL_W-1:0] tbl_lbl [K];
   logic               ins_vld [K];
   logic [30:0]        ins_key [K];
   logic [31:0]        ins_raw [K];
   logic [LABEL_W-1:0] ins_lbl [K];

   logic [CW-1:0]      count_q;
   logic [VW-1:0]      vidx_q;
   logic [VW-1:0]      votes_q [NCLS];

   logic               accept, start_clr, last_acc, vote_end;
   logic               new_nan;
   logic [30:0]        new_key;
   logic               cur_vld;
   logic [LABEL_W-1:0] cur_lbl;
   logic [LABEL_W-1:0] best_lbl;
   logic [VW-1:0]      best_cnt;

   // Sign bit is dropped so non-negative floats compare as unsigned ints;
   // NaN maps to the worst possible key.
   function automatic logic is_nan(input logic [31:0] d);
      return (&d[30:23]) && (|d[22:0]);
   endfunction

   function automatic logic [30:0] key_of(input logic [31:0] d);
      return is_nan(d) ? KEY_MAX : d[30:0];
   endfunction

   assign dist_if.dist_ready = (state_q == S_COLLECT);
   assign busy      = (state_q == S_COLLECT) || (state_q == S_VOTE);
   assign accept    = dist_if.dist_valid && dist_if.dist_ready;
   assign start_clr = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign last_acc  = accept && (count_q == CW'(NUM_ROWS - 1));
   assign vote_end  = (state_q == S_VOTE) && (vidx_q == VW'(K));
   assign new_nan   = is_nan(dist_if.dist_in);
   assign new_key   = key_of(dist_if.dist_in);

   // Next table contents if the current sample were inserted: find the first
   // slot that is empty or strictly worse, place the sample there, shift the rest.
   always_comb begin
      logic [K:0]   pre;
      logic [K-1:0] gt;
      pre = '0;
      gt  = '0;
      for (int i = 0; i < K; i++) begin
         gt[i]    = !tbl_vld[i] || (!new_nan && (tbl_key[i] > new_key));
         pre[i+1] = pre[i] | gt[i];
      end
      for (int i = 0; i < K; i++) begin
         ins_vld[i] = tbl_vld[i];
         ins_key[i] = tbl_key[i];
         ins_raw[i] = tbl_raw[i];
         ins_lbl[i] = tbl_lbl[i];
         if (gt[i] && !pre[i]) begin
            ins_vld[i] = 1'b1;
            ins_key[i] = new_key;
            ins_raw[i] = dist_if.dist_in;
            ins_lbl[i] = dist_if.label_in;
         end
      end
      for (int i = 1; i < K; i++) begin
         if (pre[i]) begin
            ins_vld[i] = tbl_vld[i-1];
            ins_key[i] = tbl_key[i-1];
            ins_raw[i] = tbl_raw[i-1];
            ins_lbl[i] = tbl_lbl[i-1];
         end
      end
   end

   // Select the table slot being tallied this cycle and find the leading
   // class; strict comparison keeps the lowest class index on ties.
   always_comb begin
      cur_vld  = 1'b0;
      cur_lbl  = '0;
      best_lbl = '0;
      best_cnt = votes_q[0];
      for (int i = 0; i < K; i++) begin
         if (vidx_q == VW'(i)) begin
            cur_vld = tbl_vld[i];
            cur_lbl = tbl_lbl[i];
         end
      end
      for (int c = 1; c < NCLS; c++) begin
         if (votes_q[c] > best_cnt) begin
            best_cnt = votes_q[c];
            best_lbl = LABEL_W'(c);
         end
      end
   end

   // Next-state logic for the collect / vote sequence.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (start)    state_d = S_COLLECT;
         S_COLLECT:      if (last_acc) state_d = S_VOTE;
         S_VOTE:         if (vote_end) state_d = S_DONE;
         default:                      state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Table, sample count, vote tally and registered results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < K; i++) begin
            tbl_vld[i] <= 1'b0;
            tbl_key[i] <= KEY_MAX;
            tbl_raw[i] <= '0;
            tbl_lbl[i] <= '0;
         end
         for (int c = 0; c < NCLS; c++) votes_q[c] <= '0;
         count_q      <= '0;
         vidx_q       <= '0;
         done         <= 1'b0;
         result_label <= '0;
         min_dist     <= '0;
      end else begin
         done <= 1'b0;
         if (start_clr) begin
            for (int i = 0; i < K; i++) begin
               tbl_vld[i] <= 1'b0;
               tbl_key[i] <= KEY_MAX;
               tbl_raw[i] <= '0;
               tbl_lbl[i] <= '0;
            end
            for (int c = 0; c < NCLS; c++) votes_q[c] <= '0;
            count_q <= '0;
            vidx_q  <= '0;
         end else if (accept) begin
            for (int i = 0; i < K; i++) begin
               tbl_vld[i] <= ins_vld[i];
               tbl_key[i] <= ins_key[i];
               tbl_raw[i] <= ins_raw[i];
               tbl_lbl[i] <= ins_lbl[i];
            end
            count_q <= count_q + CW'(1);
         end
         if (state_q == S_VOTE) begin
            if (!vote_end) begin
               if (cur_vld) votes_q[cur_lbl] <= votes_q[cur_lbl] + VW'(1);
               vidx_q <= vidx_q + VW'(1);
            end else begin
               result_label <= best_lbl;
               min_dist     <= tbl_raw[0];
               done         <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_knn_topk_vote.sv
// Bench for knn_topk_vote: five instances with different K / NUM_ROWS share
// one sample stream; only the started instance is collecting at any time.
module tb_knn_topk_vote;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dvalid = 1'b0;
   logic [31:0] din = '0;
   logic [3:0]  lin = '0;
   logic [4:0]  start_v = '0;
   logic [4:0]  rdy_v, busy_v, done_v;
   logic [3:0]  res_v [5];
   logic [31:0] min_v [5];
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   knn_topk_vote_if #(.LABEL_W(4)) if0 ();
   knn_topk_vote_if #(.LABEL_W(4)) if1 ();
   knn_topk_vote_if #(.LABEL_W(4)) if2 ();
   knn_topk_vote_if #(.LABEL_W(4)) if3 ();
   knn_topk_vote_if #(.LABEL_W(4)) if4 ();

   assign if0.dist_valid = dvalid; assign if0.dist_in = din; assign if0.label_in = lin;
   assign if1.dist_valid = dvalid; assign if1.dist_in = din; assign if1.label_in = lin;
   assign if2.dist_valid = dvalid; assign if2.dist_in = din; assign if2.label_in = lin;
   assign if3.dist_valid = dvalid; assign if3.dist_in = din; assign if3.label_in = lin;
   assign if4.dist_valid = dvalid; assign if4.dist_in = din; assign if4.label_in = lin;
   assign rdy_v = {if4.dist_ready, if3.dist_ready, if2.dist_ready, if1.dist_ready, if0.dist_ready};

   knn_topk_vote #(.K(3), .NUM_ROWS(5), .LABEL_W(4)) u0 (.clk(clk), .rst_n(rst_n), .start(start_v[0]),
      .dist_if(if0.slave), .busy(busy_v[0]), .done(done_v[0]), .result_label(res_v[0]), .min_dist(min_v[0]));
   knn_topk_vote #(.K(3), .NUM_ROWS(3), .LABEL_W(4)) u1 (.clk(clk), .rst_n(rst_n), .start(start_v[1]),
      .dist_if(if1.slave), .busy(busy_v[1]), .done(done_v[1]), .result_label(res_v[1]), .min_dist(min_v[1]));
   knn_topk_vote #(.K(1), .NUM_ROWS(2), .LABEL_W(4)) u2 (.clk(clk), .rst_n(rst_n), .start(start_v[2]),
      .dist_if(if2.slave), .busy(busy_v[2]), .done(done_v[2]), .result_label(res_v[2]), .min_dist(min_v[2]));
   knn_topk_vote #(.K(3), .NUM_ROWS(4), .LABEL_W(4)) u3 (.clk(clk), .rst_n(rst_n), .start(start_v[3]),
      .dist_if(if3.slave), .busy(busy_v[3]), .done(done_v[3]), .result_label(res_v[3]), .min_dist(min_v[3]));
   knn_topk_vote #(.K(3), .NUM_ROWS(2), .LABEL_W(4)) u4 (.clk(clk), .rst_n(rst_n), .start(start_v[4]),
      .dist_if(if4.slave), .busy(busy_v[4]), .done(done_v[4]), .result_label(res_v[4]), .min_dist(min_v[4]));

   typedef struct {
      int          tst;
      logic [31:0] d;
      logic [3:0]  l;
   } smp_t;

   typedef struct {
      int          dut;
      int          k;
      logic [3:0]  lbl;
      logic [31:0] mn;
   } tst_t;

   typedef struct {
      int          dut;
      logic [3:0]  lbl;
      logic [31:0] mn;
      int          due;
   } sb_t;

   smp_t smp [$];
   tst_t tv  [5];
   sb_t  sbq [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drive every sample of test t into its instance; optional random idle gaps
   // and start held high into COLLECT (must be ignored there).
   task automatic run_test(input int t, input bit gaps);
      int dut;
      int sent;
      dut = tv[t].dut;
      start_v[dut] = 1'b1;
      @(posedge clk); #1;
      if (!gaps) start_v[dut] = 1'b0;
      sent = 0;
      foreach (smp[j]) begin
         if (smp[j].tst == t) begin
            bit acc;
            int tries;
            if (gaps) begin
               int idle;
               idle = $urandom_range(0, 2);
               dvalid = 1'b0;
               for (int g = 0; g < idle; g++) begin
                  @(posedge clk); #1;
                  start_v[dut] = 1'b0;
               end
            end
            dvalid = 1'b1;
            din    = smp[j].d;
            lin    = smp[j].l;
            acc    = 1'b0;
            tries  = 0;
            while (!acc && tries < 20) begin
               acc = rdy_v[dut];
               @(posedge clk); #1;
               start_v[dut] = 1'b0;
               tries++;
            end
            if (!acc) chk("accept_timeout", 32'd0, 32'd1);
            sent++;
         end
      end
      dvalid = 1'b0;
      sbq.push_back('{dut, tv[t].lbl, tv[t].mn, cyc + tv[t].k + 1});
      for (int w = 0; w < 40 && sbq.size() > 0; w++) @(posedge clk);
      #1;
      chk("done_timeout", sbq.size(), 0);
      sbq.delete();
   endtask

   initial begin
      // T1 K=3,N=5
      smp.push_back('{0, 32'h4080_0000, 4'd1});
      smp.push_back('{0, 32'h3F00_0000, 4'd2});
      smp.push_back('{0, 32'h4040_0000, 4'd1});
      smp.push_back('{0, 32'h3F80_0000, 4'd2});
      smp.push_back('{0, 32'h4000_0000, 4'd3});
      // T2 K=3,N=3 three-way tie
      smp.push_back('{1, 32'h3F80_0000, 4'd3});
      smp.push_back('{1, 32'h4000_0000, 4'd1});
      smp.push_back('{1, 32'h4040_0000, 4'd2});
      // T3 K=1,N=2 equal keys
      smp.push_back('{2, 32'h3F80_0000, 4'd5});
      smp.push_back('{2, 32'h3F80_0000, 4'd6});
      // T6a K=3,N=4 NaN evicted
      smp.push_back('{3, 32'h7FC0_0000, 4'd7});
      smp.push_back('{3, 32'h4000_0000, 4'd1});
      smp.push_back('{3, 32'h4040_0000, 4'd1});
      smp.push_back('{3, 32'h4080_0000, 4'd2});
      // T6b K=3,N=2 NaN kept and voted (1-1 tie, class 2 beats 5)
      smp.push_back('{4, 32'h7FC0_0000, 4'd2});
      smp.push_back('{4, 32'h4000_0000, 4'd5});
      tv[0] = '{0, 3, 4'd2, 32'h3F00_0000};
      tv[1] = '{1, 3, 4'd1, 32'h3F80_0000};
      tv[2] = '{2, 1, 4'd5, 32'h3F80_0000};
      tv[3] = '{3, 3, 4'd1, 32'h4000_0000};
      tv[4] = '{4, 3, 4'd2, 32'h4000_0000};

      // Scoreboard monitor: every done pulse must match the queue head.
      fork
         forever begin
            @(negedge clk);
            for (int n = 0; n < 5; n++) begin
               if (done_v[n]) begin
                  if (sbq.size() == 0 || sbq[0].dut != n) begin
                     chk($sformatf("unexpected_done_u%0d", n), 32'd1, 32'd0);
                  end else begin
                     sb_t e;
                     e = sbq.pop_front();
                     chk($sformatf("label_u%0d", n), res_v[n], e.lbl);
                     chk($sformatf("min_dist_u%0d", n), min_v[n], e.mn);
                     chk($sformatf("done_cycle_u%0d", n), cyc, e.due);
                  end
               end
            end
         end
      join_none

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      for (int n = 0; n < 5; n++) begin
         chk($sformatf("rst_busy_u%0d", n), busy_v[n], 0);
         chk($sformatf("rst_ready_u%0d", n), rdy_v[n], 0);
         chk($sformatf("rst_label_u%0d", n), res_v[n], 0);
         chk($sformatf("rst_min_u%0d", n), min_v[n], 0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      // T4: valid held high in IDLE is not accepted
      dvalid = 1'b1; din = 32'h3E80_0000; lin = 4'd9;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("idle_ready", rdy_v[0], 0);
      end
      chk("idle_busy", busy_v[0], 0);
      dvalid = 1'b0;

      // Main table-driven vectors
      for (int t = 0; t < 5; t++) run_test(t, 1'b0);

      // T4: valid held high in DONE, results persist
      dvalid = 1'b1; din = 32'h3E80_0000; lin = 4'd9;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("done_ready", rdy_v[0], 0);
      end
      dvalid = 1'b0;
      chk("done_busy", busy_v[0], 0);
      chk("persist_label", res_v[0], 4'd2);
      chk("persist_min", min_v[0], 32'h3F00_0000);

      // T4: T1 again with random valid gaps and start held into COLLECT
      run_test(0, 1'b1);

      // T5: reset after two accepts, no done pulse
      start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      chk("collect_busy", busy_v[0], 1);
      dvalid = 1'b1; din = 32'h3F00_0000; lin = 4'd4;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      dvalid = 1'b0;
      chk("midrst_busy", busy_v[0], 0);
      chk("midrst_ready", rdy_v[0], 0);
      chk("midrst_label", res_v[0], 0);
      chk("midrst_min", min_v[0], 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("post_rst_done", done_v[0], 0);
      run_test(0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
